arcade_input_mux: RTL



---
 rtl/arcade_input_mux.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/arcade_input_mux.sv
`default_nettype none
// ==========================================================================
// arcade_input_mux : merges PS/2 keys and joystick words into registered
// per-player arcade controls with SOCD cleaning, coin shaping and autofire.
// Revision : 1.0
// ==========================================================================
module arcade_input_mux #(
   parameter int PLAYERS      = 2,
   parameter int BUTTONS      = 3,
   parameter int COIN_CYCLES  = 96000,
   parameter int AUTOFIRE_DIV = 3200000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [10:0]                ps2_key,
   input  logic [32*PLAYERS-1:0]      joy,
   input  logic [1:0]                 socd_mode,
   input  logic [BUTTONS-1:0]         autofire_mask,
   output logic [4*PLAYERS-1:0]       dir,
   output logic [BUTTONS*PLAYERS-1:0] btn,
   output logic [PLAYERS-1:0]         start,
   output logic [PLAYERS-1:0]         coin,
   output logic                       pause
);

   localparam int CW   = $clog2(COIN_CYCLES + 1);
   localparam int AW   = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
   localparam int NK   = 9;
   localparam int K_R  = 0;
   localparam int K_L  = 1;
   localparam int K_D  = 2;
   localparam int K_U  = 3;
   localparam int K_B1 = 4;
   localparam int K_ST = 7;
   localparam int K_CN = 8;

   logic                       init_q;
   logic                       tog_q;
   logic [2*NK-1:0]            key_q, key_d;
   logic                       kpause_q, kpause_d;
   logic                       w_evt;
   logic [AW-1:0]              af_cnt_q;
   logic                       af_phase_q;
   logic [4*PLAYERS-1:0]       dir_d;
   logic [BUTTONS*PLAYERS-1:0] btn_d;
   logic [PLAYERS-1:0]         start_d;
   logic [PLAYERS-1:0]         w_pause_p;
   logic                       pause_d;
   logic                       w_unused;

   assign w_unused = ^{ps2_key[8], key_q};

   // init_q masks the first clock after reset so a stale toggle level is not taken as an event
   assign w_evt = init_q && (ps2_key[10] != tog_q);

   always_comb begin
      key_d    = key_q;
      kpause_d = kpause_q;
      if (w_evt) begin
         case (ps2_key[7:0])
            8'h75:   key_d[K_U]       = ps2_key[9];
            8'h72:   key_d[K_D]       = ps2_key[9];
            8'h6B:   key_d[K_L]       = ps2_key[9];
            8'h74:   key_d[K_R]       = ps2_key[9];
            8'h14:   key_d[K_B1]      = ps2_key[9];
            8'h11:   key_d[K_B1+1]    = ps2_key[9];
            8'h29:   key_d[K_B1+2]    = ps2_key[9];
            8'h16:   key_d[K_ST]      = ps2_key[9];
            8'h2E:   key_d[K_CN]      = ps2_key[9];
            8'h4D:   kpause_d         = ps2_key[9];
            8'h2D:   key_d[NK+K_U]    = ps2_key[9];
            8'h2B:   key_d[NK+K_D]    = ps2_key[9];
            8'h23:   key_d[NK+K_L]    = ps2_key[9];
            8'h34:   key_d[NK+K_R]    = ps2_key[9];
            8'h1C:   key_d[NK+K_B1]   = ps2_key[9];
            8'h1B:   key_d[NK+K_B1+1] = ps2_key[9];
            8'h15:   key_d[NK+K_B1+2] = ps2_key[9];
            8'h1E:   key_d[NK+K_ST]   = ps2_key[9];
            8'h36:   key_d[NK+K_CN]   = ps2_key[9];
            default: key_d            = key_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         init_q   <= 1'b0;
         tog_q    <= 1'b0;
         key_q    <= '0;
         kpause_q <= 1'b0;
      end else begin
         init_q   <= 1'b1;
         tog_q    <= ps2_key[10];
         key_q    <= key_d;
         kpause_q <= kpause_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         af_cnt_q   <= '0;
         af_phase_q <= 1'b1;
      end else if (af_cnt_q == AW'(AUTOFIRE_DIV - 1)) begin
         af_cnt_q   <= '0;
         af_phase_q <= ~af_phase_q;
      end else begin
         af_cnt_q   <= af_cnt_q + AW'(1);
      end
   end

   for (genvar p = 0; p < PLAYERS; p++) begin : g_player
      logic [31:0]   w_joy;
      logic [NK-1:0] w_key;
      logic [3:0]    w_dir_raw;
      logic [3:0]    w_dir_clean;
      logic          w_coin_raw;
      logic          w_unused_in;
      logic          coin_prev_q;
      logic [CW-1:0] coin_cnt_q, coin_cnt_d;

      assign w_joy = joy[32*p +: 32];

      if (p < 2) begin : g_kbd
         assign w_key = key_q[NK*p +: NK];
      end else begin : g_nokbd
         assign w_key = '0;
      end

      assign w_unused_in = ^{w_joy, w_key};

      // packed as {U,D,R,L} so each axis is an adjacent bit pair
      assign w_dir_raw = {w_joy[3] | w_key[K_U], w_joy[2] | w_key[K_D],
                          w_joy[0] | w_key[K_R], w_joy[1] | w_key[K_L]};

      for (genvar a = 0; a < 2; a++) begin : g_axis
         logic [1:0] w_pair, w_rise, w_out;
         logic [1:0] prev_q, win_q, win_d;

         assign w_pair = w_dir_raw[2*a +: 2];
         assign w_rise = w_pair & ~prev_q;

         always_comb begin
            win_d = win_q;
            case (w_rise)
               2'b01:   win_d = 2'b01;
               2'b10:   win_d = 2'b10;
               2'b11:   win_d = 2'b00;
               default: win_d = win_q;
            endcase
            w_out = w_pair;
            if (w_pair == 2'b11) begin
               case (socd_mode)
                  2'd0:    w_out = 2'b11;
                  2'd2:    w_out = win_d;
                  default: w_out = 2'b00;
               endcase
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               prev_q <= 2'b00;
               win_q  <= 2'b00;
            end else begin
               prev_q <= w_pair;
               win_q  <= win_d;
            end
         end

         assign w_dir_clean[2*a +: 2] = w_out;
      end

      assign dir_d[4*p +: 4] = w_dir_clean;

      for (genvar i = 0; i < BUTTONS; i++) begin : g_btn
         logic w_raw;
         if (i < 3) begin : g_kb
            assign w_raw = w_joy[4+i] | w_key[K_B1+i];
         end else begin : g_js
            assign w_raw = w_joy[4+i];
         end
         assign btn_d[BUTTONS*p + i] = w_raw & (autofire_mask[i] ? af_phase_q : 1'b1);
      end

      assign start_d[p]   = w_joy[4+BUTTONS] | w_key[K_ST];
      assign w_coin_raw   = w_joy[5+BUTTONS] | w_key[K_CN];
      assign w_pause_p[p] = w_joy[6+BUTTONS];

      // a rise only arms the counter when idle, so presses during a pulse are dropped
      always_comb begin
         coin_cnt_d = coin_cnt_q;
         if (coin_cnt_q != '0)
            coin_cnt_d = coin_cnt_q - CW'(1);
         else if (w_coin_raw && !coin_prev_q)
            coin_cnt_d = CW'(COIN_CYCLES);
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            coin_prev_q <= 1'b0;
            coin_cnt_q  <= '0;
         end else begin
            coin_prev_q <= w_coin_raw;
            coin_cnt_q  <= coin_cnt_d;
         end
      end

      assign coin[p] = (coin_cnt_q != '0);
   end

   assign pause_d = (|w_pause_p) | kpause_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dir   <= '0;
         btn   <= '0;
         start <= '0;
         pause <= 1'b0;
      end else begin
         dir   <= dir_d;
         btn   <= btn_d;
         start <= start_d;
         pause <= pause_d;
      end
   end

endmodule
`default_nettype wire
